sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 119 +++++++++++
 tb/tb_sram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter sharing one async SRAM, IDLE->ACCESS->DONE per transaction.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is port 0 priority.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [19:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic [15:0] req0_rdata,
  output logic        req0_done,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [19:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic [15:0] req1_rdata,
  output logic        req1_done,
  output logic [19:0] ADDR,
  output logic [15:0] Data_write,
  input  logic [15:0] Data_read,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        tristate_oe,
  output logic [1:0]  grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        wr_q, wr_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        r0, r1, pick1, acc;
  assign r0 = req0_rd | req0_wr;
  assign r1 = req1_rd | req1_wr;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q set means port 1 owned the previous grant
  assign pick1 = r1 & (~r0 | ~last_q);
`else
  assign pick1 = r1 & ~r0;
`endif
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif
    if (state_q == IDLE && (r0 | r1)) begin
      state_d = ACCESS;
      cnt_d   = 4'(WAIT_CYCLES - 1);
      grant_d = pick1 ? 2'b10 : 2'b01;
      wr_d    = pick1 ? req1_wr : req0_wr;
      addr_d  = pick1 ? req1_addr : req0_addr;
      wdata_d = pick1 ? req1_wdata : req0_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_d  = pick1;
`endif
    end else if (state_q == ACCESS) begin
      state_d  = (cnt_q == 4'd0) ? DONE : ACCESS;
      cnt_d    = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
      rdata0_d = (cnt_q == 4'd0 && !wr_q && grant_q[0]) ? Data_read : rdata0_q;
      rdata1_d = (cnt_q == 4'd0 && !wr_q && grant_q[1]) ? Data_read : rdata1_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      grant_d = 2'b00;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      grant_q  <= 2'b00;
      wr_q     <= 1'b0;
      addr_q   <= 20'd0;
      wdata_q  <= 16'd0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end
  assign acc         = state_q == ACCESS;
  assign busy        = state_q != IDLE;
  assign grant       = grant_q;
  assign Mem_CE      = ~acc;
  assign Mem_OE      = ~(acc & ~wr_q);
  assign Mem_WE      = ~(acc & wr_q);
  assign tristate_oe = acc & wr_q;
  assign ADDR        = addr_q;
  assign Data_write  = wdata_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign req0_done   = state_q == DONE && grant_q[0];
  assign req1_done   = state_q == DONE && grant_q[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: table of whole transactions on a WAIT_CYCLES=2 arbiter, plus reset-abort
// and back-to-back timing sequences on WAIT_CYCLES=1 and 15 instances.
module tb_sram_arbiter;
  localparam int W = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [19:0] a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0, dr = 0;
  logic [15:0] rdata0, rdata1, dwrite;
  logic [19:0] addr;
  logic        done0, done1, ce, oe, we, toe, busy;
  logic [1:0]  grant;
  logic        xrd [2];
  logic        xce [2], xdone [2], xoe [2], xwe [2], xtoe [2], xbusy [2], xd1 [2];
  logic [15:0] xrdata [2], xr1 [2], xdw [2];
  logic [19:0] xaddr [2];
  logic [1:0]  xgrant [2];
  int nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(clk), .Reset(rst),
    .req0_rd(rd0), .req0_wr(wr0), .req0_addr(a0), .req0_wdata(d0), .req0_rdata(rdata0), .req0_done(done0),
    .req1_rd(rd1), .req1_wr(wr1), .req1_addr(a1), .req1_wdata(d1), .req1_rdata(rdata1), .req1_done(done1),
    .ADDR(addr), .Data_write(dwrite), .Data_read(dr),
    .Mem_CE(ce), .Mem_OE(oe), .Mem_WE(we), .tristate_oe(toe), .grant(grant), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(clk), .Reset(rst),
    .req0_rd(xrd[0]), .req0_wr(1'b0), .req0_addr(20'h00001), .req0_wdata(16'h0), .req0_rdata(xrdata[0]), .req0_done(xdone[0]),
    .req1_rd(1'b0), .req1_wr(1'b0), .req1_addr(20'h0), .req1_wdata(16'h0), .req1_rdata(xr1[0]), .req1_done(xd1[0]),
    .ADDR(xaddr[0]), .Data_write(xdw[0]), .Data_read(16'h1111),
    .Mem_CE(xce[0]), .Mem_OE(xoe[0]), .Mem_WE(xwe[0]), .tristate_oe(xtoe[0]), .grant(xgrant[0]), .busy(xbusy[0])
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(clk), .Reset(rst),
    .req0_rd(xrd[1]), .req0_wr(1'b0), .req0_addr(20'h00002), .req0_wdata(16'h0), .req0_rdata(xrdata[1]), .req0_done(xdone[1]),
    .req1_rd(1'b0), .req1_wr(1'b0), .req1_addr(20'h0), .req1_wdata(16'h0), .req1_rdata(xr1[1]), .req1_done(xd1[1]),
    .ADDR(xaddr[1]), .Data_write(xdw[1]), .Data_read(16'h2222),
    .Mem_CE(xce[1]), .Mem_OE(xoe[1]), .Mem_WE(xwe[1]), .tristate_oe(xtoe[1]), .grant(xgrant[1]), .busy(xbusy[1])
  );

  typedef struct {
    logic rd0, wr0, rd1, wr1;
    logic [19:0] a0, a1;
    logic [15:0] d0, d1, dr;
    logic [1:0]  g;
    logic        wr;
    logic [19:0] ea;
    logic [15:0] ewd, er0, er1;
    int          idle;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic txn(input int i, input vec_t v);
    int acc = 0, idl = 0;
    logic got = 0, bad = 0;
    @(negedge clk);
    rd0 = v.rd0; wr0 = v.wr0; rd1 = v.rd1; wr1 = v.wr1;
    a0 = v.a0; a1 = v.a1; d0 = v.d0; d1 = v.d1; dr = v.dr;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (!busy) begin
        idl++;
        if (grant != 2'b00 || done0 || done1 || !ce || !oe || !we || toe) bad = 1;
      end else if (!ce) begin
        acc++;
        if (grant != v.g || addr != v.ea || oe != v.wr || we != !v.wr || toe != v.wr) bad = 1;
        if (v.wr && dwrite != v.ewd) bad = 1;
      end else got = done0 | done1;
    end
    $display("vector %0d", i);
    chk("done_seen", got, 1);
    chk("idle_gap", idl, v.idle);
    chk("access_len", acc, W);
    chk("strobes", bad, 0);
    chk("done_port", {done1, done0}, v.g);
    chk("grant_done", grant, v.g);
    chk("rdata0", rdata0, v.er0);
    chk("rdata1", rdata1, v.er1);
    chk("addr_hold", addr, v.ea);
    chk("strobes_done", {ce, oe, we, toe}, 4'b1110);
    if (v.wr) chk("data_write", dwrite, v.ewd);
  endtask

  task automatic gap_test(input int k, input int w, input logic [15:0] exp_rd);
    int ph = 0, a1c = 0, a2c = 0, gap = 0;
    logic a, d;
    @(negedge clk);
    xrd[k] = 1'b1;
    for (int c = 0; c < 80 && ph != 4; c++) begin
      @(posedge clk); #1;
      a = !xce[k];
      d = xdone[k];
      if (ph == 0 && a) ph = 1;
      if (ph == 1) begin
        if (a) a1c++;
        else if (d) ph = 2;
      end else if (ph == 2) begin
        if (a) begin ph = 3; a2c = 1; end
        else gap++;
      end else if (ph == 3) begin
        if (a) a2c++;
        else if (d) ph = 4;
      end
    end
    @(negedge clk);
    xrd[k] = 1'b0;
    chk("b2b_complete", ph, 4);
    chk("b2b_access1", a1c, w);
    chk("b2b_access2", a2c, w);
    chk("b2b_gap", gap, 1);
    chk("b2b_rdata", xrdata[k], exp_rd);
  endtask

  initial begin
    logic seen;
    xrd[0] = 0; xrd[1] = 0;
    //          rd0 wr0 rd1 wr1  a0         a1         d0        d1        dr        g      wr  ea         ewd       er0       er1     idle
    vt[0] = '{1, 0, 0, 0, 20'h00123, 20'h00000, 16'h0000, 16'h0000, 16'hBEEF, 2'b01, 0, 20'h00123, 16'h0000, 16'hBEEF, 16'h0000, 0};
    vt[1] = '{0, 0, 0, 1, 20'h00000, 20'h0FFFF, 16'h0000, 16'hA5A5, 16'h0000, 2'b10, 1, 20'h0FFFF, 16'hA5A5, 16'hBEEF, 16'h0000, 1};
    vt[2] = '{0, 0, 1, 0, 20'h00000, 20'h00042, 16'h0000, 16'h0000, 16'h1234, 2'b10, 0, 20'h00042, 16'h0000, 16'hBEEF, 16'h1234, 1};
    vt[3] = '{0, 0, 1, 1, 20'h00000, 20'hFFFFF, 16'h0000, 16'h0F0F, 16'h0000, 2'b10, 1, 20'hFFFFF, 16'h0F0F, 16'hBEEF, 16'h1234, 1};
    vt[4] = '{1, 0, 1, 0, 20'h00010, 20'h00020, 16'h0000, 16'h0000, 16'h5555, 2'b01, 0, 20'h00010, 16'h0000, 16'h5555, 16'h1234, 1};
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    vt[5] = '{1, 0, 1, 0, 20'h00010, 20'h00020, 16'h0000, 16'h0000, 16'h6666, 2'b10, 0, 20'h00020, 16'h0000, 16'h5555, 16'h6666, 1};
    vt[6] = '{1, 0, 1, 0, 20'h00010, 20'h00020, 16'h0000, 16'h0000, 16'h7777, 2'b01, 0, 20'h00010, 16'h0000, 16'h7777, 16'h6666, 1};
    vt[7] = '{0, 0, 1, 0, 20'h00000, 20'h00ABC, 16'h0000, 16'h0000, 16'h9999, 2'b10, 0, 20'h00ABC, 16'h0000, 16'h7777, 16'h9999, 1};
`else
    vt[5] = '{1, 0, 1, 0, 20'h00010, 20'h00020, 16'h0000, 16'h0000, 16'h6666, 2'b01, 0, 20'h00010, 16'h0000, 16'h6666, 16'h1234, 1};
    vt[6] = '{1, 0, 1, 0, 20'h00010, 20'h00020, 16'h0000, 16'h0000, 16'h7777, 2'b01, 0, 20'h00010, 16'h0000, 16'h7777, 16'h1234, 1};
    vt[7] = '{0, 0, 1, 0, 20'h00000, 20'h00ABC, 16'h0000, 16'h0000, 16'h9999, 2'b10, 0, 20'h00ABC, 16'h0000, 16'h7777, 16'h9999, 1};
`endif
    vt[8] = '{0, 0, 1, 0, 20'h00000, 20'h00ABD, 16'h0000, 16'h0000, 16'h8888, 2'b10, 0, 20'h00ABD, 16'h0000, 16'h7777, 16'h8888, 1};
    vt[9] = '{0, 1, 0, 0, 20'h00001, 20'h00000, 16'h0000, 16'hFFFF, 16'h0000, 2'b01, 1, 20'h00001, 16'h0000, 16'h7777, 16'h8888, 1};
    vt[9].d0 = 16'hFFFF;
    vt[9].ewd = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_strobes", {ce, oe, we, toe}, 4'b1110);
    chk("rst_addr", addr, 20'h0);
    chk("rst_dwrite", dwrite, 16'h0);
    chk("rst_rdata", {rdata0, rdata1}, 32'h0);
    chk("rst_done", {done0, done1}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) txn(i, vt[i]);
    // abort a port 0 write in its first ACCESS cycle
    @(negedge clk);
    rd0 = 0; wr0 = 1; rd1 = 0; wr1 = 0; a0 = 20'h12345; d0 = 16'hCAFE;
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);
    @(posedge clk); #1;
    chk("abort_we_low", {ce, we, toe}, 3'b001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {ce, oe, we, toe}, 4'b1110);
    chk("abort_grant", grant, 2'b00);
    chk("abort_rdata", {rdata0, rdata1}, 32'h0);
    chk("abort_addr", addr, 20'h0);
    @(negedge clk);
    rst = 1'b0;
    wr0 = 0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | done0 | done1 | busy;
    end
    chk("abort_no_done", seen, 0);
    gap_test(0, 1, 16'h1111);
    gap_test(1, 15, 16'h2222);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
